// File: rtl/clk_div_prog.sv
// rtl/clk_div_prog.sv - programmable multi-channel clock-enable generator
// Each channel divides clk by (D+1) into tick/sq/frame enables; divisors double-buffered.
module clk_div_prog #(
  parameter int CNT_W       = 16,
  parameter int N_CH        = 2,
  parameter int DEFAULT_DIV = 31250,
  parameter int FRAME_TICKS = 16,
  parameter int SEL_W       = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   en,
  input  logic [N_CH-1:0]   mode,
  input  logic              sync,
  input  logic              div_wr,
  input  logic [SEL_W-1:0]  div_sel,
  input  logic [CNT_W-1:0]  div_data,
  output logic [N_CH-1:0]   tick,
  output logic [N_CH-1:0]   sq,
  output logic [N_CH-1:0]   frame
);

  localparam int FC_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
  localparam logic [FC_W-1:0]  FC_LAST = FC_W'(FRAME_TICKS - 1);

  logic [N_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [N_CH-1:0][CNT_W-1:0] div_act_q, div_act_d;
  logic [N_CH-1:0][CNT_W-1:0] div_shd_q, div_shd_d;
  logic [N_CH-1:0][CNT_W-1:0] shd_eff;
  logic [N_CH-1:0][FC_W-1:0]  fcnt_q, fcnt_d;
  logic [N_CH-1:0]            tick_q, tick_d;
  logic [N_CH-1:0]            sq_q, sq_d;
  logic [N_CH-1:0]            frame_q, frame_d;

  always_comb begin
    cnt_d     = cnt_q;
    div_act_d = div_act_q;
    fcnt_d    = fcnt_q;
    shd_eff   = div_shd_q;
    div_shd_d = div_shd_q;
    tick_d    = '0;
    sq_d      = '0;
    frame_d   = '0;
    for (int i = 0; i < N_CH; i++) begin
      // A write in the same cycle as a reload wins, so it shapes the period starting now.
      if (div_wr && (div_sel == SEL_W'(i))) begin
        shd_eff[i] = div_data;
      end
      div_shd_d[i] = shd_eff[i];
      if (sync || !en[i]) begin
        cnt_d[i]     = '0;
        fcnt_d[i]    = '0;
        div_act_d[i] = shd_eff[i];
      end else if (cnt_q[i] == div_act_q[i]) begin
        cnt_d[i]     = '0;
        tick_d[i]    = 1'b1;
        div_act_d[i] = shd_eff[i];
        sq_d[i]      = mode[i] & ~sq_q[i];
        if (fcnt_q[i] == FC_LAST) begin
          fcnt_d[i]  = '0;
          frame_d[i] = 1'b1;
        end else begin
          fcnt_d[i]  = fcnt_q[i] + FC_W'(1);
        end
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
        sq_d[i]  = mode[i] & sq_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      fcnt_q    <= '0;
      div_act_q <= {N_CH{DIV_RST}};
      div_shd_q <= {N_CH{DIV_RST}};
      tick_q    <= '0;
      sq_q      <= '0;
      frame_q   <= '0;
    end else begin
      cnt_q     <= cnt_d;
      fcnt_q    <= fcnt_d;
      div_act_q <= div_act_d;
      div_shd_q <= div_shd_d;
      tick_q    <= tick_d;
      sq_q      <= sq_d;
      frame_q   <= frame_d;
    end
  end

  assign tick  = tick_q;
  assign sq    = sq_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// tb/tb_clk_div_prog.sv - directed, table-driven bench for clk_div_prog
module tb_clk_div_prog;

  typedef struct packed {
    logic [1:0]  en;
    logic [1:0]  mode;
    logic        sync;
    logic        wr;
    logic [15:0] data;
    logic [1:0]  t;
    logic [1:0]  s;
    logic [1:0]  f;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  en, mode, tick, sq, frame;
  logic        sync, div_wr, div_sel;
  logic [15:0] div_data;

  logic [2:0]  en3, mode3, tick3, sq3, frame3;
  logic        sync3, wr3;
  logic [1:0]  sel3;
  logic [15:0] data3;

  int   n_chk  = 0;
  int   n_fail = 0;
  vec_t tbl [19];

  always #5 clk = ~clk;

  clk_div_prog #(.CNT_W(16), .N_CH(2), .DEFAULT_DIV(4), .FRAME_TICKS(4), .SEL_W(1)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sync(sync), .div_wr(div_wr),
    .div_sel(div_sel), .div_data(div_data), .tick(tick), .sq(sq), .frame(frame)
  );

  clk_div_prog #(.CNT_W(16), .N_CH(3), .DEFAULT_DIV(4), .FRAME_TICKS(4), .SEL_W(2)) dut3 (
    .clk(clk), .rst(rst), .en(en3), .mode(mode3), .sync(sync3), .div_wr(wr3),
    .div_sel(sel3), .div_data(data3), .tick(tick3), .sq(sq3), .frame(frame3)
  );

  function automatic vec_t mk(input logic [1:0] e, input logic [1:0] m, input logic s,
                              input logic w, input logic [15:0] d, input logic [1:0] t,
                              input logic [1:0] q, input logic [1:0] f);
    vec_t v;
    v.en = e; v.mode = m; v.sync = s; v.wr = w; v.data = d; v.t = t; v.s = q; v.f = f;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic step(input string nm, input logic [1:0] et, input logic [1:0] es,
                      input logic [1:0] ef);
    @(posedge clk);
    #1;
    chk(nm, 32'({tick, sq, frame}), 32'({et, es, ef}));
  endtask

  task automatic step3(input string nm, input logic [2:0] et, input logic [2:0] ef);
    @(posedge clk);
    #1;
    chk(nm, 32'({tick3, frame3}), 32'({et, ef}));
  endtask

  task automatic apply(input int i);
    en = tbl[i].en; mode = tbl[i].mode; sync = tbl[i].sync;
    div_wr = tbl[i].wr; div_sel = 1'b0; div_data = tbl[i].data;
    step($sformatf("tbl%0d", i), tbl[i].t, tbl[i].s, tbl[i].f);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; en = '0; mode = '0; sync = 1'b0; div_wr = 1'b0; div_sel = 1'b0; div_data = '0;
    en3 = '0; mode3 = '0; sync3 = 1'b0; wr3 = 1'b0; sel3 = '0; data3 = '0;

    // Reset run (D=4) edges 1..10, then D=0 square run preceded by a sync+write row.
    for (int e = 1; e <= 10; e++)
      tbl[e-1] = mk(2'b01, 2'b00, 1'b0, 1'b0, 16'd0, (e % 5 == 0) ? 2'b01 : 2'b00, 2'b00, 2'b00);
    tbl[10] = mk(2'b01, 2'b01, 1'b1, 1'b1, 16'd0, 2'b00, 2'b00, 2'b00);
    for (int e = 1; e <= 8; e++)
      tbl[10+e] = mk(2'b01, 2'b01, 1'b0, 1'b0, 16'd0, 2'b01,
                     (e % 2 == 1) ? 2'b01 : 2'b00, (e % 4 == 0) ? 2'b01 : 2'b00);

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 32'({tick, sq, frame}), 32'd0);
    chk("reset_outputs3", 32'({tick3, sq3, frame3}), 32'd0);

    rst = 1'b1;
    for (int i = 0; i < 10; i++) apply(i);
    for (int e = 11; e <= 40; e++)
      step("reset_run", (e % 5 == 0) ? 2'b01 : 2'b00, 2'b00, (e % 20 == 0) ? 2'b01 : 2'b00);

    // Square mode, D=4
    mode = 2'b01; sync = 1'b1;
    step("sq_sync", 2'b00, 2'b00, 2'b00);
    sync = 1'b0;
    for (int e = 1; e <= 20; e++)
      step("sq_d4", (e % 5 == 0) ? 2'b01 : 2'b00, ((e / 5) % 2 == 1) ? 2'b01 : 2'b00,
           (e % 20 == 0) ? 2'b01 : 2'b00);

    for (int i = 10; i < 19; i++) apply(i);

    // Divisor write mid-period and in the wrap cycle
    mode = 2'b00; sync = 1'b1; div_wr = 1'b1; div_sel = 1'b0; div_data = 16'd4;
    step("wr_sync", 2'b00, 2'b00, 2'b00);
    sync = 1'b0; div_wr = 1'b0;
    step("wr_e1", 2'b00, 2'b00, 2'b00);
    div_wr = 1'b1; div_data = 16'd2;
    step("wr_e2", 2'b00, 2'b00, 2'b00);
    div_wr = 1'b0;
    for (int e = 3; e <= 16; e++)
      step("wr_mid", (e == 5 || e == 8 || e == 11 || e == 14) ? 2'b01 : 2'b00, 2'b00,
           (e == 14) ? 2'b01 : 2'b00);
    div_wr = 1'b1; div_data = 16'd6;
    step("wr_at_wrap", 2'b01, 2'b00, 2'b00);
    div_wr = 1'b0;
    for (int e = 18; e <= 31; e++)
      step("wr_after_wrap", (e == 24 || e == 31) ? 2'b01 : 2'b00, 2'b00, 2'b00);

    // Per-channel write: ch1 gets D=1, ch0 keeps D=6
    div_wr = 1'b1; div_sel = 1'b1; div_data = 16'd1;
    step("sel1_wr", 2'b00, 2'b00, 2'b00);
    div_wr = 1'b0; sync = 1'b1; en = 2'b11;
    step("sel1_sync", 2'b00, 2'b00, 2'b00);
    sync = 1'b0;
    for (int e = 1; e <= 14; e++)
      step("sel1_run", {(e % 2 == 0), (e % 7 == 0)}, 2'b00, {(e == 8), 1'b0});

    // Staggered enable, then sync aligns both channels
    en = 2'b00; div_wr = 1'b1; div_sel = 1'b0; div_data = 16'd4;
    step("al_wr0", 2'b00, 2'b00, 2'b00);
    div_sel = 1'b1;
    step("al_wr1", 2'b00, 2'b00, 2'b00);
    div_wr = 1'b0; en = 2'b01; mode = 2'b11;
    step("al_e1", 2'b00, 2'b00, 2'b00);
    step("al_e2", 2'b00, 2'b00, 2'b00);
    en = 2'b11;
    step("al_e3", 2'b00, 2'b00, 2'b00);
    step("al_e4", 2'b00, 2'b00, 2'b00);
    step("al_e5", 2'b01, 2'b01, 2'b00);
    step("al_e6", 2'b00, 2'b01, 2'b00);
    sync = 1'b1;
    step("al_sync", 2'b00, 2'b00, 2'b00);
    sync = 1'b0;
    for (int e = 1; e <= 20; e++)
      step("al_run", (e % 5 == 0) ? 2'b11 : 2'b00, ((e / 5) % 2 == 1) ? 2'b11 : 2'b00,
           (e == 20) ? 2'b11 : 2'b00);

    // Drop en at cnt=3, re-enable for a full period
    for (int e = 21; e <= 23; e++) step("en_pre", 2'b00, 2'b00, 2'b00);
    en = 2'b00;
    step("en_drop", 2'b00, 2'b00, 2'b00);
    step("en_idle", 2'b00, 2'b00, 2'b00);
    en = 2'b01; mode = 2'b01;
    for (int e = 1; e <= 5; e++)
      step("en_again", (e == 5) ? 2'b01 : 2'b00, (e == 5) ? 2'b01 : 2'b00, 2'b00);

    // Async reset between edges discards a programmed divisor
    div_wr = 1'b1; div_sel = 1'b0; div_data = 16'd1;
    step("rst_pre", 2'b00, 2'b01, 2'b00);
    div_wr = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("rst_async", 32'({tick, sq, frame}), 32'd0);
    step("rst_hold", 2'b00, 2'b00, 2'b00);
    rst = 1'b1;
    for (int e = 1; e <= 10; e++)
      step("rst_after", (e % 5 == 0) ? 2'b01 : 2'b00, (e >= 5 && e <= 9) ? 2'b01 : 2'b00, 2'b00);

    // Three-channel instance: div_sel=3 ignored, div_sel=2 hits ch2 only
    en = 2'b00;
    en3 = 3'b111; sync3 = 1'b1; wr3 = 1'b1; sel3 = 2'd3; data3 = 16'd1;
    step3("sel3_sync", 3'b000, 3'b000);
    sync3 = 1'b0; wr3 = 1'b0;
    for (int e = 1; e <= 10; e++)
      step3("sel3_run", (e % 5 == 0) ? 3'b111 : 3'b000, 3'b000);
    sync3 = 1'b1; wr3 = 1'b1; sel3 = 2'd2;
    step3("sel2_sync", 3'b000, 3'b000);
    sync3 = 1'b0; wr3 = 1'b0;
    for (int e = 1; e <= 10; e++)
      step3("sel2_run", {(e % 2 == 0), (e % 5 == 0), (e % 5 == 0)}, {(e == 8), 2'b00});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
